fpu_arbiter: RTL and testbench

- Shares one fpu instance between REQUESTERS independent clients using round-robin arbitration.
- Latches the winning client's operands and operation, then sequences the fpu's input and output handshakes.
- Returns the result to the winning client only.
- A watchdog converts a hung fpu transaction into an error response and pulses a flush to the fpu.

---
 rtl/fpu_arbiter_if.sv | 40 ++++
 rtl/fpu_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fpu_arbiter.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_arbiter_if.sv
// Client and fpu-side signals of the fpu arbiter. The arbiter takes the slave
// modport; the clients plus the fpu together form the master side.
interface fpu_arbiter_if #(
  parameter int unsigned bitness    = 32,
  parameter int unsigned REQUESTERS = 4
);
  logic [REQUESTERS-1:0]         req_valid;
  logic [REQUESTERS-1:0]         req_ack;
  logic [REQUESTERS*bitness-1:0] req_data_a;
  logic [REQUESTERS*bitness-1:0] req_data_b;
  logic [REQUESTERS*4-1:0]       req_op;
  logic [REQUESTERS-1:0]         rsp_valid;
  logic [REQUESTERS-1:0]         rsp_ack;
  logic [bitness-1:0]            rsp_result;
  logic                          rsp_error;
  logic                          fpu_input_rdy;
  logic                          fpu_input_ack;
  logic                          fpu_output_rdy;
  logic                          fpu_output_ack;
  logic [bitness-1:0]            fpu_data_a;
  logic [bitness-1:0]            fpu_data_b;
  logic [3:0]                    fpu_operation;
  logic [bitness-1:0]            fpu_result;
  logic                          fpu_flush;
  logic                          busy;

  modport slave (
    input  req_valid, req_data_a, req_data_b, req_op, rsp_ack,
           fpu_input_ack, fpu_output_rdy, fpu_result,
    output req_ack, rsp_valid, rsp_result, rsp_error, fpu_input_rdy, fpu_output_ack,
           fpu_data_a, fpu_data_b, fpu_operation, fpu_flush, busy
  );

  modport master (
    output req_valid, req_data_a, req_data_b, req_op, rsp_ack,
           fpu_input_ack, fpu_output_rdy, fpu_result,
    input  req_ack, rsp_valid, rsp_result, rsp_error, fpu_input_rdy, fpu_output_ack,
           fpu_data_a, fpu_data_b, fpu_operation, fpu_flush, busy
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one fpu between REQUESTERS clients, with a
// watchdog that turns a hung fpu transaction into an error response.
module fpu_arbiter #(
   parameter int unsigned bitness    = 32,
   parameter int unsigned REQUESTERS = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input logic           clock,
   input logic           reset,
   fpu_arbiter_if.slave  bus
);
   localparam int unsigned IdxW   = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
   localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
   localparam logic [bitness-1:0] AbortResult = {1'b0, {(bitness - 1){1'b1}}};

   typedef enum logic [2:0] {
      StIdle, StIssue, StWaitResult, StAckFpu, StRespond, StAbort
   } state_e;

   state_e              state_q, state_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [IdxW-1:0]     last_q, last_d;
   logic [bitness-1:0]  a_q, a_d;
   logic [bitness-1:0]  b_q, b_d;
   logic [3:0]          op_q, op_d;
   logic [bitness-1:0]  result_q, result_d;
   logic                error_q, error_d;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic                first_q, first_d;

   logic [bitness-1:0]  req_a [REQUESTERS];
   logic [bitness-1:0]  req_b [REQUESTERS];
   logic [3:0]          req_o [REQUESTERS];

   for (genvar g = 0; g < REQUESTERS; g++) begin : g_unpack
      assign req_a[g] = bus.req_data_a[g*bitness +: bitness];
      assign req_b[g] = bus.req_data_b[g*bitness +: bitness];
      assign req_o[g] = bus.req_op[g*4 +: 4];
   end

   logic            pick_valid;
   logic [IdxW-1:0] pick_idx;
   logic [IdxW-1:0] cand_idx;

   // Search starts one past the last served client so every requester is reached.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand_idx   = '0;
      for (int unsigned i = 1; i <= REQUESTERS; i++) begin
         cand_idx = IdxW'((32'(last_q) + i) % REQUESTERS);
         if (!pick_valid && bus.req_valid[cand_idx]) begin
            pick_valid = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   logic timer_expired;
   assign timer_expired = (timer_q == TimerW'(TIMEOUT - 1));

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      last_d   = last_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      error_d  = error_q;
      timer_d  = timer_q;
      first_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (pick_valid) begin
               idx_d   = pick_idx;
               a_d     = req_a[pick_idx];
               b_d     = req_b[pick_idx];
               op_d    = req_o[pick_idx];
               timer_d = '0;
               first_d = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            timer_d = timer_q + TimerW'(1);
            if (bus.fpu_input_ack) begin
               state_d = StWaitResult;
            end else if (timer_expired) begin
               result_d = AbortResult;
               error_d  = 1'b1;
               state_d  = StAbort;
            end
         end
         StWaitResult: begin
            timer_d = timer_q + TimerW'(1);
            if (bus.fpu_output_rdy) begin
               result_d = bus.fpu_result;
               error_d  = 1'b0;
               state_d  = StAckFpu;
            end else if (timer_expired) begin
               result_d = AbortResult;
               error_d  = 1'b1;
               state_d  = StAbort;
            end
         end
         StAckFpu: state_d = StRespond;
         StAbort:  state_d = StRespond;
         StRespond: begin
            if (bus.rsp_ack[idx_q]) begin
               last_d  = idx_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         last_q   <= IdxW'(REQUESTERS - 1);
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         error_q  <= 1'b0;
         timer_q  <= '0;
         first_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         error_q  <= error_d;
         timer_q  <= timer_d;
         first_q  <= first_d;
      end
   end

   // Every output is decoded from registered state only.
   logic [REQUESTERS-1:0] idx_onehot;
   assign idx_onehot = {{(REQUESTERS - 1){1'b0}}, 1'b1} << idx_q;

   assign bus.req_ack        = (state_q == StIssue && first_q) ? idx_onehot : '0;
   assign bus.rsp_valid      = (state_q == StRespond) ? idx_onehot : '0;
   assign bus.rsp_result     = result_q;
   assign bus.rsp_error      = error_q;
   assign bus.fpu_input_rdy  = (state_q == StIssue);
   assign bus.fpu_output_ack = (state_q == StAckFpu);
   assign bus.fpu_flush      = (state_q == StAbort);
   assign bus.fpu_data_a     = a_q;
   assign bus.fpu_data_b     = b_q;
   assign bus.fpu_operation  = op_q;
   assign bus.busy           = (state_q != StIdle);
endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: behavioural fpu model plus a scoreboard of expected
// client responses, one task per scenario.
module tb_fpu_arbiter;
   localparam int unsigned W  = 32;
   localparam int unsigned N  = 4;
   localparam int unsigned TO = 64;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   fpu_arbiter_if #(.bitness(W), .REQUESTERS(N)) bus();
   fpu_arbiter #(.bitness(W), .REQUESTERS(N), .TIMEOUT(TO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          client;
      logic [31:0] result;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   ack_cnt[N];
   int   last_grant  = -1;
   int   cyc         = 0;
   bit   fpu_hang    = 1'b0;
   bit   fpu_kill    = 1'b0;
   int   fpu_lat     = 2;

   function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
      return (a ^ {b[15:0], b[31:16]}) + {28'd0, op};
   endfunction

   // Behavioural fpu: acks input, answers after fpu_lat cycles unless hung.
   initial begin
      bit          pending;
      int          cnt;
      logic [31:0] cap_a, cap_b;
      logic [3:0]  cap_op;
      pending = 1'b0;
      cnt     = 0;
      cap_a   = '0;
      cap_b   = '0;
      cap_op  = '0;
      bus.fpu_input_ack  = 1'b0;
      bus.fpu_output_rdy = 1'b0;
      bus.fpu_result     = '0;
      forever begin
         @(negedge clock);
         if (fpu_kill || bus.fpu_flush) begin
            bus.fpu_input_ack  = 1'b0;
            bus.fpu_output_rdy = 1'b0;
            pending            = 1'b0;
         end else if (bus.fpu_input_ack) begin
            bus.fpu_input_ack = 1'b0;
         end else if (bus.fpu_output_rdy) begin
            if (bus.fpu_output_ack) begin
               bus.fpu_output_rdy = 1'b0;
               pending            = 1'b0;
            end
         end else if (pending) begin
            if (!fpu_hang) begin
               if (cnt == 0) begin
                  bus.fpu_output_rdy = 1'b1;
                  bus.fpu_result     = fmodel(cap_a, cap_b, cap_op);
               end else begin
                  cnt--;
               end
            end
         end else if (bus.fpu_input_rdy) begin
            bus.fpu_input_ack = 1'b1;
            cap_a   = bus.fpu_data_a;
            cap_b   = bus.fpu_data_b;
            cap_op  = bus.fpu_operation;
            pending = 1'b1;
            cnt     = fpu_lat;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (bus.req_ack[i]) begin
            ack_cnt[i]++;
            last_grant = i;
         end
      end
   endtask

   task automatic set_client(input int c, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] op);
      bus.req_data_a[c*W +: W] = a;
      bus.req_data_b[c*W +: W] = b;
      bus.req_op[c*4 +: 4]     = op;
   endtask

   task automatic push_exp(input int c, input bit err);
      exp_t e;
      e.client = c;
      e.err    = err;
      e.result = err ? 32'h7FFF_FFFF
                     : fmodel(bus.req_data_a[c*W +: W], bus.req_data_b[c*W +: W],
                              bus.req_op[c*4 +: 4]);
      sb.push_back(e);
   endtask

   task automatic wait_rsp(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         if (|bus.rsp_valid) got = 1'b1;
         else tick();
      end
      if (|bus.rsp_valid) got = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      vectors++;
      if ({bus.busy, bus.rsp_valid, bus.req_ack, bus.fpu_input_rdy, bus.fpu_output_ack,
           bus.fpu_flush, bus.rsp_error} !== '0) begin
         miscompares++;
         $display("FAIL reset_ctrl: busy=%b rsp_valid=%b req_ack=%b in_rdy=%b, want all 0",
                  bus.busy, bus.rsp_valid, bus.req_ack, bus.fpu_input_rdy);
      end
      vectors++;
      if ({bus.rsp_result, bus.fpu_data_a, bus.fpu_data_b, bus.fpu_operation} !== '0) begin
         miscompares++;
         $display("FAIL reset_data: result=%h a=%h b=%h op=%h, want 0", bus.rsp_result,
                  bus.fpu_data_a, bus.fpu_data_b, bus.fpu_operation);
      end
      reset = 1'b0;
      tick();
      vectors++;
      if (bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_no_req: busy=%b, want 0", bus.busy);
      end
   endtask

   task automatic test_single();
      exp_t e;
      bit   got;
      int   a0, t_oack;
      set_client(2, 32'h3F80_0000, 32'h4000_0000, 4'b0000);
      push_exp(2, 1'b0);
      a0 = ack_cnt[2];
      bus.req_valid[2] = 1'b1;
      tick();
      vectors++;
      if (bus.req_ack !== 4'b0100 || bus.fpu_input_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL single_issue: req_ack=%b in_rdy=%b, want 0100 1", bus.req_ack,
                  bus.fpu_input_rdy);
      end
      bus.req_valid[2] = 1'b0;
      vectors++;
      if (bus.fpu_operation !== 4'b0000 || bus.fpu_data_a !== 32'h3F80_0000 ||
          bus.fpu_data_b !== 32'h4000_0000) begin
         miscompares++;
         $display("FAIL single_operands: op=%b a=%h b=%h, want 0000 3f800000 40000000",
                  bus.fpu_operation, bus.fpu_data_a, bus.fpu_data_b);
      end
      t_oack = -1;
      got    = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if (bus.fpu_output_ack) t_oack = cyc;
         if (|bus.rsp_valid) got = 1'b1;
      end
      vectors++;
      if (t_oack < 0 || cyc != t_oack + 1) begin
         miscompares++;
         $display("FAIL single_latency: output_ack at %0d rsp_valid at %0d, want 1 apart",
                  t_oack, cyc);
      end
      e = sb.pop_front();
      vectors++;
      if (!got || bus.rsp_valid !== 4'(1 << e.client) || bus.rsp_result !== e.result ||
          bus.rsp_error !== e.err) begin
         miscompares++;
         $display("FAIL single_rsp: valid=%b result=%h err=%b, want valid=%b result=%h err=%b",
                  bus.rsp_valid, bus.rsp_result, bus.rsp_error, 4'(1 << e.client), e.result,
                  e.err);
      end
      vectors++;
      if (ack_cnt[2] - a0 != 1) begin
         miscompares++;
         $display("FAIL single_ack_count: %0d req_ack pulses, want 1", ack_cnt[2] - a0);
      end
      bus.rsp_ack[2] = 1'b1;
      tick();
      bus.rsp_ack = '0;
      vectors++;
      if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000) begin
         miscompares++;
         $display("FAIL single_idle: busy=%b rsp_valid=%b, want 0 0000", bus.busy,
                  bus.rsp_valid);
      end
   endtask

   task automatic test_contention();
      exp_t e;
      bit   got;
      int   base[N];
      int   want[N] = '{2, 1, 1, 1};
      reset = 1'b1;
      for (int c = 0; c < N; c++) begin
         set_client(c, 32'h1000_0000 * (c + 1) + 32'h55, 32'h0ABC_0000 + c, 4'(c + 1));
      end
      bus.req_valid = 4'hF;
      tick();
      tick();
      reset = 1'b0;
      for (int c = 0; c < N; c++) base[c] = ack_cnt[c];
      push_exp(0, 1'b0);
      push_exp(1, 1'b0);
      push_exp(2, 1'b0);
      push_exp(3, 1'b0);
      push_exp(0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         wait_rsp(40, got);
         e = sb.pop_front();
         vectors++;
         if (!got || bus.rsp_valid !== 4'(1 << e.client) || bus.rsp_result !== e.result ||
             bus.rsp_error !== e.err || last_grant != e.client) begin
            miscompares++;
            $display("FAIL contention_rsp[%0d]: valid=%b result=%h grant=%0d, want valid=%b result=%h grant=%0d",
                     k, bus.rsp_valid, bus.rsp_result, last_grant, 4'(1 << e.client),
                     e.result, e.client);
         end
         bus.rsp_ack[e.client] = 1'b1;
         if (k == 4) bus.req_valid = '0;
         tick();
         bus.rsp_ack = '0;
      end
      tick();
      tick();
      for (int c = 0; c < N; c++) begin
         vectors++;
         if (ack_cnt[c] - base[c] != want[c]) begin
            miscompares++;
            $display("FAIL contention_count[%0d]: %0d grants, want %0d", c,
                     ack_cnt[c] - base[c], want[c]);
         end
      end
   endtask

   task automatic test_late_joiner();
      exp_t e;
      bit   got;
      set_client(1, 32'hC000_0001, 32'h1234_5678, 4'b0011);
      push_exp(1, 1'b0);
      bus.req_valid = 4'b0010;
      wait_rsp(40, got);
      bus.req_valid[1] = 1'b0;
      set_client(0, 32'h0000_00AA, 32'hBEEF_0000, 4'b0001);
      set_client(3, 32'h7777_0000, 32'h0000_3333, 4'b0010);
      bus.req_valid[0] = 1'b1;
      bus.req_valid[3] = 1'b1;
      tick();
      tick();
      push_exp(3, 1'b0);
      push_exp(0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) wait_rsp(40, got);
         e = sb.pop_front();
         vectors++;
         if (!got || bus.rsp_valid !== 4'(1 << e.client) || bus.rsp_result !== e.result ||
             bus.rsp_error !== e.err) begin
            miscompares++;
            $display("FAIL late_rsp[%0d]: valid=%b result=%h, want valid=%b result=%h", k,
                     bus.rsp_valid, bus.rsp_result, 4'(1 << e.client), e.result);
         end
         bus.rsp_ack[e.client]   = 1'b1;
         bus.req_valid[e.client] = 1'b0;
         tick();
         bus.rsp_ack = '0;
      end
   endtask

   task automatic test_hung_fpu();
      exp_t e;
      bit   got;
      int   t0, flush_t;
      fpu_hang = 1'b1;
      set_client(1, 32'h4040_0000, 32'h4080_0000, 4'b0101);
      push_exp(1, 1'b1);
      bus.req_valid[1] = 1'b1;
      t0      = cyc;
      flush_t = -1;
      for (int i = 0; i < 100 && flush_t < 0; i++) begin
         tick();
         if (bus.req_ack[1]) bus.req_valid[1] = 1'b0;
         if (bus.fpu_flush) flush_t = cyc - t0;
      end
      vectors++;
      if (flush_t != 65) begin
         miscompares++;
         $display("FAIL hung_flush_cycle: flush at cycle %0d, want 65", flush_t);
      end
      vectors++;
      if (bus.rsp_result !== 32'h7FFF_FFFF || bus.rsp_error !== 1'b1) begin
         miscompares++;
         $display("FAIL hung_abort_value: result=%h err=%b, want 7fffffff 1", bus.rsp_result,
                  bus.rsp_error);
      end
      fpu_hang = 1'b0;
      tick();
      vectors++;
      if (bus.fpu_flush !== 1'b0) begin
         miscompares++;
         $display("FAIL hung_flush_pulse: flush=%b one cycle later, want 0", bus.fpu_flush);
      end
      set_client(2, 32'h3F00_0000, 32'h3E00_0000, 4'b0001);
      push_exp(2, 1'b0);
      bus.req_valid[2] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         wait_rsp(40, got);
         e = sb.pop_front();
         vectors++;
         if (!got || bus.rsp_valid !== 4'(1 << e.client) || bus.rsp_result !== e.result ||
             bus.rsp_error !== e.err) begin
            miscompares++;
            $display("FAIL hung_rsp[%0d]: valid=%b result=%h err=%b, want valid=%b result=%h err=%b",
                     k, bus.rsp_valid, bus.rsp_result, bus.rsp_error, 4'(1 << e.client),
                     e.result, e.err);
         end
         bus.rsp_ack[e.client]   = 1'b1;
         bus.req_valid[e.client] = 1'b0;
         tick();
         bus.rsp_ack = '0;
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bit   got;
      bit   quiet;
      fpu_lat = 10;
      set_client(3, 32'h0101_0101, 32'h0202_0202, 4'b1111);
      bus.req_valid[3] = 1'b1;
      tick();
      bus.req_valid = '0;
      tick();
      tick();
      tick();
      vectors++;
      if (bus.busy !== 1'b1 || bus.fpu_input_rdy !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_in_wait: busy=%b in_rdy=%b, want 1 0", bus.busy, bus.fpu_input_rdy);
      end
      reset = 1'b1;
      tick();
      vectors++;
      if ({bus.busy, bus.rsp_valid, bus.req_ack, bus.fpu_input_rdy, bus.fpu_output_ack,
           bus.fpu_flush, bus.rsp_error, bus.rsp_result, bus.fpu_data_a, bus.fpu_data_b,
           bus.fpu_operation} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_outputs: busy=%b a=%h op=%h result=%h, want all 0",
                  bus.busy, bus.fpu_data_a, bus.fpu_operation, bus.rsp_result);
      end
      reset = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000 || bus.fpu_output_ack !== 1'b0)
            quiet = 1'b0;
      end
      vectors++;
      if (!quiet) begin
         miscompares++;
         $display("FAIL mid_ignore_late_result: busy=%b rsp_valid=%b, want 0 0000", bus.busy,
                  bus.rsp_valid);
      end
      fpu_kill = 1'b1;
      tick();
      fpu_kill = 1'b0;
      fpu_lat  = 2;
      set_client(1, 32'hAAAA_0000, 32'h0000_5555, 4'b0100);
      set_client(2, 32'h1111_1111, 32'h2222_2222, 4'b0110);
      push_exp(1, 1'b0);
      bus.req_valid = 4'b0110;
      wait_rsp(40, got);
      e = sb.pop_front();
      vectors++;
      if (!got || bus.rsp_valid !== 4'(1 << e.client) || bus.rsp_result !== e.result ||
          last_grant != e.client) begin
         miscompares++;
         $display("FAIL mid_next_grant: valid=%b grant=%0d result=%h, want valid=%b grant=%0d result=%h",
                  bus.rsp_valid, last_grant, bus.rsp_result, 4'(1 << e.client), e.client,
                  e.result);
      end
      bus.rsp_ack[1] = 1'b1;
      bus.req_valid  = '0;
      tick();
      bus.rsp_ack = '0;
      tick();
   endtask

   task automatic test_slow_client();
      exp_t e;
      bit   got;
      bit   stable;
      int   acks0, acks1;
      set_client(0, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 4'b1001);
      set_client(2, 32'h0000_1234, 32'h5678_0000, 4'b0010);
      push_exp(0, 1'b0);
      bus.req_valid[0] = 1'b1;
      wait_rsp(40, got);
      bus.req_valid[0] = 1'b0;
      e = sb.pop_front();
      vectors++;
      if (!got || bus.rsp_valid !== 4'(1 << e.client) || bus.rsp_result !== e.result) begin
         miscompares++;
         $display("FAIL slow_rsp: valid=%b result=%h, want valid=%b result=%h", bus.rsp_valid,
                  bus.rsp_result, 4'(1 << e.client), e.result);
      end
      bus.req_valid[2] = 1'b1;
      bus.rsp_ack      = 4'b1110;
      acks0  = ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3];
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.rsp_valid !== 4'b0001 || bus.rsp_result !== e.result ||
             bus.rsp_error !== 1'b0) stable = 1'b0;
      end
      acks1 = ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3];
      vectors++;
      if (!stable) begin
         miscompares++;
         $display("FAIL slow_hold: valid=%b result=%h, want 0001 %h held", bus.rsp_valid,
                  bus.rsp_result, e.result);
      end
      vectors++;
      if (acks1 != acks0) begin
         miscompares++;
         $display("FAIL slow_no_new_ack: %0d req_ack pulses while held, want 0", acks1 - acks0);
      end
      push_exp(2, 1'b0);
      bus.rsp_ack = 4'b0001;
      tick();
      bus.rsp_ack = '0;
      wait_rsp(40, got);
      e = sb.pop_front();
      vectors++;
      if (!got || bus.rsp_valid !== 4'(1 << e.client) || bus.rsp_result !== e.result) begin
         miscompares++;
         $display("FAIL slow_next: valid=%b result=%h, want valid=%b result=%h", bus.rsp_valid,
                  bus.rsp_result, 4'(1 << e.client), e.result);
      end
      bus.rsp_ack[2]   = 1'b1;
      bus.req_valid[2] = 1'b0;
      tick();
      bus.rsp_ack = '0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) ack_cnt[i] = 0;
      bus.req_valid  = '0;
      bus.req_data_a = '0;
      bus.req_data_b = '0;
      bus.req_op     = '0;
      bus.rsp_ack    = '0;
      test_reset();
      test_single();
      test_contention();
      test_late_joiner();
      test_hung_fpu();
      test_reset_mid();
      test_slow_client();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
